// File: rtl/rr_arbiter_enc_pkg.sv
// Shared types and constants for the round-robin encoder-lane arbiter.
// State encoding, default sizing and the mod-N index increment used by the pointer update.
package arb_pkg;

    localparam int ARB_N_DEFAULT        = 8;
    localparam int ARB_MAX_HOLD_DEFAULT = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_TURN = 2'd2;

    // Wraps at n-1 back to 0, so a pointer built from it never reaches n.
    function automatic int inc_mod(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_enc_if.sv
// Request/grant bundle between the requesting blocks and the encoder-lane arbiter.
// Handshake: a requester holds req[i] high for as long as it wants the lane; it owns the lane
// while gnt[i] is high, and drops req[i] to release it. gnt_valid == |gnt, and gnt_idx names
// the owner whenever gnt_valid is high.
interface rr_arbiter_enc_if
    import arb_pkg::*;
#(
    parameter int N = ARB_N_DEFAULT
);
    localparam int IDX_W = $clog2(N);

    logic             en;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output en, req,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  en, req,
        output gnt, gnt_idx, gnt_valid, timeout
    );

endinterface

// File: rtl/rr_arbiter_enc_pick.sv
// Combinational round-robin search: first set req bit at or above ptr, wrapping at N-1 to 0.
// Produces a one-hot pick, its binary index and a found flag.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = ARB_N_DEFAULT,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int               pos;
    logic [IDX_W-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = 0;
        cand   = '0;
        for (int i = 0; i < N; i++) begin
            pos  = (int'(ptr) + i) % N;
            cand = IDX_W'(pos);
            if (!found && req[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_enc.sv
// Round-robin arbiter for a shared encoder/decoder lane: registered one-hot grant plus index,
// held until released. Optional forced release after MAX_HOLD cycles under ARB_TIMEOUT_EN.
module rr_arbiter_enc
    import arb_pkg::*;
#(
    parameter int N = ARB_N_DEFAULT
`ifdef ARB_TIMEOUT_EN
    , parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_arbiter_enc_if.slave   bus,
    output state_t            dbg_state
);

    localparam int IDX_W = $clog2(N);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [N-1:0]     pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             take;
    logic             owner_req;
    logic             release_now;

    rr_pick #(.N(N)) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    assign take      = bus.en && pick_found;
    assign owner_req = bus.req[bus.gnt_idx];
    assign dbg_state = state;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              forced;

    // hold_cnt counts BUSY edges already survived, so the edge ending cycle MAX_HOLD sees MAX_HOLD-1.
    assign forced      = owner_req && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign release_now = !owner_req || forced;
`else
    assign release_now = !owner_req;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            bus.gnt       <= '0;
            bus.gnt_idx   <= '0;
            bus.gnt_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt      <= '0;
            bus.timeout   <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            bus.timeout <= 1'b0;
`endif
            case (state)
                // TURN is the single dead cycle after a release; its closing edge arbitrates
                // exactly like IDLE, using the already-advanced pointer.
                ST_IDLE, ST_TURN: begin
                    if (take) begin
                        bus.gnt       <= pick_onehot;
                        bus.gnt_idx   <= pick_idx;
                        bus.gnt_valid <= 1'b1;
                        state         <= ST_BUSY;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt      <= '0;
`endif
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (release_now) begin
                        bus.gnt       <= '0;
                        bus.gnt_valid <= 1'b0;
                        ptr           <= IDX_W'(inc_mod(int'(bus.gnt_idx), N));
                        state         <= ST_TURN;
`ifdef ARB_TIMEOUT_EN
                        bus.timeout   <= forced;
`endif
                    end
`ifdef ARB_TIMEOUT_EN
                    if (!release_now) hold_cnt <= hold_cnt + HOLD_W'(1);
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_enc.sv
// Directed bench for rr_arbiter_enc (N=8): reset, single request, fairness, wrap, enable, hold.
// With ARB_TIMEOUT_EN defined the hold section exercises forced release at MAX_HOLD=4.
module tb_rr_arbiter_enc;
    import arb_pkg::*;

    localparam int N = 8;

    logic clk;
    logic rst_n;
    state_t dbg_state;
    int checks = 0;
    int errors = 0;

    rr_arbiter_enc_if #(.N(N)) bus ();

`ifdef ARB_TIMEOUT_EN
    rr_arbiter_enc #(.N(N), .MAX_HOLD(4)) dut (
`else
    rr_arbiter_enc #(.N(N)) dut (
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic [7:0] g, input logic [2:0] idx, input logic v);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, ".idx"}, 32'(bus.gnt_idx), 32'(idx));
        chk({tag, ".valid"}, 32'(bus.gnt_valid), 32'(v));
    endtask

    // Structural invariants, sampled mid-cycle.
    always @(negedge clk) begin
        checks++;
        assert ($onehot0(bus.gnt) && (bus.gnt_valid === (bus.gnt != '0)) &&
                (!bus.gnt_valid || bus.gnt === (8'h01 << bus.gnt_idx))) else begin
            errors++;
            $error("FAIL invariant: gnt=%0h idx=%0d valid=%0b", bus.gnt, bus.gnt_idx, bus.gnt_valid);
        end
    end

    logic [7:0] fair_oh  [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [2:0] fair_idx [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

    initial begin
        rst_n   = 1'b0;
        bus.en  = 1'b1;
        bus.req = 8'hFF;
        step(); step(); step();
        chk_gnt("reset", 8'h00, 3'd0, 1'b0);
        chk("reset.timeout", 32'(bus.timeout), 32'd0);
        chk("reset.state", 32'(dbg_state), 32'(ST_IDLE));

        rst_n = 1'b1;
        step();
        chk_gnt("first", 8'h01, 3'd0, 1'b1);
        bus.req = 8'h00;
        step();
        chk_gnt("first_rel", 8'h00, 3'd0, 1'b0);
        chk("first_rel.state", 32'(dbg_state), 32'(ST_TURN));
        step();
        chk("first_idle.state", 32'(dbg_state), 32'(ST_IDLE));

        // Single request, ptr=1 -> idx 2.
        bus.req = 8'h04;
        step();
        chk_gnt("single", 8'h04, 3'd2, 1'b1);
        bus.req = 8'h00;
        step();
        chk_gnt("single_rel", 8'h00, 3'd2, 1'b0);
        step(); step();
        chk_gnt("single_idle", 8'h00, 3'd2, 1'b0);
        chk("single_idle.state", 32'(dbg_state), 32'(ST_IDLE));

        // Reset asserted mid-grant clears immediately (ptr=3 -> idx 3 first).
        bus.req = 8'hFF;
        step();
        chk_gnt("pre_rst", 8'h08, 3'd3, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_gnt("mid_rst", 8'h00, 3'd0, 1'b0);
        chk("mid_rst.state", 32'(dbg_state), 32'(ST_IDLE));
        step();
        rst_n = 1'b1;
        step();

        // Fairness: each owner keeps the lane 2 cycles, drops, re-raises.
        for (int k = 0; k < 9; k++) begin
            chk_gnt($sformatf("fair%0d", k), fair_oh[k], fair_idx[k], 1'b1);
            if (k == 8) break;
            step();
            chk("fair_hold.gnt", 32'(bus.gnt), 32'(fair_oh[k]));
            bus.req = bus.req & ~fair_oh[k];
            step();
            chk("fair_gap.gnt", 32'(bus.gnt), 32'd0);
            bus.req = bus.req | fair_oh[k];
            step();
        end

        // Wrap: release idx 6 (ptr=7), then 8'h81 -> idx 7, then idx 0.
        bus.req = 8'h40;
        step(); step();
        chk_gnt("wrap6", 8'h40, 3'd6, 1'b1);
        bus.req = 8'h00;
        step();
        bus.req = 8'h81;
        step();
        chk_gnt("wrap7", 8'h80, 3'd7, 1'b1);
        bus.req = 8'h01;
        step(); step();
        chk_gnt("wrap0", 8'h01, 3'd0, 1'b1);
        bus.req = 8'h00;
        step(); step();

        // Enable gating.
        bus.en  = 1'b0;
        bus.req = 8'h10;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("en_off.gnt", 32'(bus.gnt), 32'd0);
        end
        bus.en = 1'b1;
        step();
        chk_gnt("en_on", 8'h10, 3'd4, 1'b1);
        bus.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_gnt("en_drop_hold", 8'h10, 3'd4, 1'b1);
        end
        bus.req = 8'h00;
        step();
        chk_gnt("en_rel", 8'h00, 3'd4, 1'b0);
        step(); step();
        chk("en_idle.gnt", 32'(bus.gnt), 32'd0);
        bus.en = 1'b1;
        step();

        // Hold behaviour with req=8'h03 held (ptr=5 -> idx 0 first).
        bus.req = 8'h03;
        step();
        chk_gnt("hold_start", 8'h01, 3'd0, 1'b1);
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 3; k++) begin
            step();
            chk_gnt("hold0", 8'h01, 3'd0, 1'b1);
            chk("hold0.timeout", 32'(bus.timeout), 32'd0);
        end
        step();
        chk_gnt("forced0", 8'h00, 3'd0, 1'b0);
        chk("forced0.timeout", 32'(bus.timeout), 32'd1);
        step();
        chk_gnt("hold1_start", 8'h02, 3'd1, 1'b1);
        chk("hold1.timeout", 32'(bus.timeout), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_gnt("hold1", 8'h02, 3'd1, 1'b1);
        end
        step();
        chk_gnt("forced1", 8'h00, 3'd1, 1'b0);
        chk("forced1.timeout", 32'(bus.timeout), 32'd1);
`else
        for (int k = 0; k < 20; k++) begin
            step();
            chk_gnt("hold_forever", 8'h01, 3'd0, 1'b1);
            chk("hold_forever.timeout", 32'(bus.timeout), 32'd0);
        end
`endif
        bus.req = 8'h00;
        step(); step();
        chk("final.gnt", 32'(bus.gnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
